sp_mem_arbiter: RTL and testbench
=================================

// Module: sp_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port memory (valid/ready, wr_rd, addr, wdata, rdata)
//  between NUM_REQ requesters. Latches one request, drives the memory-side handshake, routes
//  rdata/ready back to the winner. Adds a per-transaction watchdog. Sits between the
//  requester masters and single_port.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  ADDR_W      8    memory address width
//  DATA_W      32   memory data width
//  TIMEOUT     16   max cycles mem_valid may wait for mem_ready before abort (>=2)
// PORTS
//  clk        in   1               clock, all logic on posedge
//  rst        in   1               synchronous, active-low reset
//  req_valid  in   NUM_REQ         per-requester request; held until its req_ready
//  req_wr_rd  in   NUM_REQ         1=write, 0=read, per requester
//  req_addr   in   NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W  packed write data
//  req_ready  out  NUM_REQ         one-hot 1-cycle completion pulse
//  req_rdata  out  DATA_W          read data, valid when req_ready[i] and read
//  req_err    out  NUM_REQ         one-hot 1-cycle pulse: transaction timed out
//  mem_valid  out  1               to memory valid
//  mem_wr_rd  out  1               to memory wr_rd
//  mem_addr   out  ADDR_W          to memory addr
//  mem_wdata  out  DATA_W          to memory wdata
//  mem_rdata  in   DATA_W          from memory rdata
//  mem_ready  in   1               from memory ready
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE; mem_valid/req_ready/req_err=0; mem_addr, mem_wdata,
//    mem_wr_rd, req_rdata=0; last_grant=NUM_REQ-1 (port 0 wins first); watchdog=0.
//    Reset mid-transaction drops mem_valid next edge, no completion pulse issued.
//  - FSM states: IDLE, BUSY, DONE.
//  - IDLE: if |req_valid, pick first set bit searching from last_grant+1 with wrap;
//    register grant, wr_rd, addr, wdata; -> BUSY. mem_valid=1 from next cycle.
//  - BUSY: mem_valid=1, fields stable. If mem_ready: capture mem_rdata into req_rdata,
//    pulse req_ready[grant] next cycle, last_grant<=grant, mem_valid<=0, -> DONE.
//    Else watchdog++; when watchdog reaches TIMEOUT-1 without mem_ready: pulse req_err[grant],
//    mem_valid<=0, last_grant<=grant, -> DONE.
//  - DONE: one bubble cycle (req_ready/req_err high here); -> IDLE. The bubble lets the
//    requester drop req_valid before re-arbitration, so the same request is never re-granted.
//  - Latency: req_valid seen at edge N -> mem_valid at N+1 -> with 1-cycle memory ready at
//    N+2 -> req_ready at N+3. Back-to-back throughput: one transaction per 4 cycles.
//  - Writes: req_rdata is left unchanged (no capture) on write completion.
//  - mem_ready while IDLE/DONE is ignored. Changes to the winner's req_* during BUSY are ignored.
//  - Simultaneous requests: strict rotation, no requester starved (max wait NUM_REQ-1 grants).
//  - mem_ready on the same edge the watchdog expires: completion wins, no err.
// STRUCTURE
//  - Package sp_arb_pkg: typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
//    localparam WR=1'b1, RD=1'b0.
//  - Sub-module rr_picker #(N): combinational; inputs req[N], last[$clog2(N)];
//    outputs gnt_idx, gnt_any. Arbiter instantiates it once.
// TESTING
//  - Reset: hold rst=0 3 cycles with req_valid=4'b1111 -> mem_valid, req_ready, req_err stay 0.
//  - Single write then read: port 2 writes addr 8'h10 data 32'hDEADBEEF, then reads 8'h10
//    -> mem sees wr_rd=1 then 0 at 8'h10. Read completes with req_ready=4'b0100,
//    req_rdata=32'hDEADBEEF, 3-cycle latency each.
//  - Contention: all 4 ports assert reads at once, each held until its ready -> grant order 0,1,2,3.
//    Then 1 and 3 re-request -> order 1,3 (last_grant=3 -> wraps to 0, picks 1... then 3).
//  - Timeout: memory model never asserts ready for port 1 -> req_err=4'b0010 exactly
//    TIMEOUT cycles after mem_valid rose. mem_valid drops, port 2 then serviced normally.
//  - Reset mid-op: assert rst=0 while BUSY -> mem_valid 0 next edge, no req_ready. After
//    release, port 0 is granted first.
//  - Ready at expiry edge: mem_ready on cycle TIMEOUT-1 -> req_ready pulses, req_err stays 0.

Source files
------------

// File: rtl/sp_mem_arbiter_pkg.sv
// Shared types for the single-port memory arbiter.
// FSM encoding and the write/read strobe values.
package sp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } arb_state_t;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

endpackage

// File: rtl/sp_mem_arbiter_if.sv
// Requester-side and memory-side bundle of the arbiter.
// master = arbiter view, slave = requesters plus memory.
interface sp_mem_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_wr_rd;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         req_rdata;
   logic [NUM_REQ-1:0]        req_err;

   logic                      mem_valid;
   logic                      mem_wr_rd;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      mem_ready;

   modport master (
      input  req_valid, req_wr_rd, req_addr, req_wdata,
      input  mem_rdata, mem_ready,
      output req_ready, req_rdata, req_err,
      output mem_valid, mem_wr_rd, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_wr_rd, req_addr, req_wdata,
      output mem_rdata, mem_ready,
      input  req_ready, req_rdata, req_err,
      input  mem_valid, mem_wr_rd, mem_addr, mem_wdata
   );

endinterface

// File: rtl/sp_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request
// found searching upward from last+1 with wrap-around.
module rr_picker #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [IW-1:0] idx;

   // Walk from farthest to nearest so the nearest hit is written last.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % N);
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory
// between NUM_REQ requesters, with a per-transaction watchdog.
module sp_mem_arbiter
   import sp_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic               clk,
   input logic               rst,
   sp_mem_arbiter_if.master  bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT);

   arb_state_t          state_q, state_d;
   logic [IW-1:0]       grant_q, grant_d;
   logic [IW-1:0]       last_q, last_d;
   logic                wr_rd_q, wr_rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [NUM_REQ-1:0]  ready_q, ready_d;
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic [WW-1:0]       wdog_q, wdog_d;

   logic [IW-1:0]       gnt_idx;
   logic                gnt_any;

   rr_picker #(.N(NUM_REQ)) u_pick (
      .req     (bus.req_valid),
      .last    (last_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wr_rd_d = wr_rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ready_d = '0;
      err_d   = '0;
      wdog_d  = wdog_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_any) begin
               grant_d = gnt_idx;
               wr_rd_d = bus.req_wr_rd[gnt_idx] ? WR : RD;
               addr_d  = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
               wdata_d = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
               wdog_d  = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // A ready on the expiry edge still counts as completion.
            if (bus.mem_ready) begin
               if (wr_rd_q == RD) rdata_d = bus.mem_rdata;
               ready_d[grant_q] = 1'b1;
               last_d  = grant_q;
               state_d = DONE;
            end else if (wdog_q == WW'(TIMEOUT - 1)) begin
               err_d[grant_q] = 1'b1;
               last_d  = grant_q;
               state_d = DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         wr_rd_q <= RD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= '0;
         err_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wr_rd_q <= wr_rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

   assign bus.mem_valid = (state_q == BUSY);
   assign bus.mem_wr_rd = wr_rd_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.req_rdata = rdata_q;
   assign bus.req_ready = ready_q;
   assign bus.req_err   = err_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Self-checking bench for sp_mem_arbiter: memory model,
// transaction-level round-robin reference, directed and random batches.
module tb_sp_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sp_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sp_mem_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memory: ready mem_lat cycles after valid, never for stall_addr
   logic [DW-1:0] mem [256];
   int            mem_cnt;
   int            mem_lat    = 1;
   logic          stall_en   = 1'b0;
   logic [AW-1:0] stall_addr = 8'hEE;

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A50000 + i;
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= '0;
         mem_cnt       <= 0;
      end else if (!bus.mem_valid || bus.mem_ready) begin
         bus.mem_ready <= 1'b0;
         mem_cnt       <= 0;
      end else if (mem_cnt + 1 >= mem_lat &&
                   !(stall_en && bus.mem_addr == stall_addr)) begin
         bus.mem_ready <= 1'b1;
         if (bus.mem_wr_rd) mem[bus.mem_addr] <= bus.mem_wdata;
         else bus.mem_rdata <= mem[bus.mem_addr];
      end else begin
         mem_cnt <= mem_cnt + 1;
      end
   end

   int            checks   = 0;
   int            failures = 0;
   int            last_m;
   logic [DW-1:0] ref_mem [256];
   logic          op_wr   [N];
   logic [AW-1:0] op_addr [N];
   logic [DW-1:0] op_wd   [N];
   logic          scramble = 1'b0;

   function automatic int rr_pick(input logic [N-1:0] pend, input int last);
      for (int k = 1; k <= N; k++)
         if (pend[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic ref_init();
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5A50000 + i;
      last_m = N - 1;
   endtask

   task automatic run_batch(input logic [N-1:0] mask);
      logic [N-1:0]  pend;
      logic [N-1:0]  oh;
      logic [DW-1:0] rd_before;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      int            cur, t, t_valid, t_done;
      pend = mask;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]           = mask[i];
         bus.req_wr_rd[i]           = op_wr[i];
         bus.req_addr[i*AW +: AW]   = op_addr[i];
         bus.req_wdata[i*DW +: DW]  = op_wd[i];
      end
      t = 0;
      t_valid = 1;
      rd_before = bus.req_rdata;
      while (pend != 0) begin
         cur = rr_pick(pend, last_m);
         exp_err = (stall_en && op_addr[cur] == stall_addr) || mem_lat >= TO;
         t_done = t_valid + (exp_err ? TO : mem_lat + 1);
         oh = '0;
         oh[cur] = 1'b1;
         do begin
            @(negedge clk);
            t++;
            if (t < t_valid) begin
               checks++;
               if (bus.mem_valid !== 1'b0 || bus.req_ready !== '0 ||
                   bus.req_err !== '0) begin
                  failures++;
                  $display("FAIL gap t=%0d: valid=%b ready=%b err=%b, required 0",
                           t, bus.mem_valid, bus.req_ready, bus.req_err);
               end
            end else if (t < t_done) begin
               checks++;
               if (bus.mem_valid !== 1'b1 || bus.mem_wr_rd !== op_wr[cur] ||
                   bus.mem_addr !== op_addr[cur] ||
                   (op_wr[cur] && bus.mem_wdata !== op_wd[cur]) ||
                   bus.req_ready !== '0 || bus.req_err !== '0) begin
                  failures++;
                  $display("FAIL issue port%0d t=%0d: valid=%b wr=%b addr=%h wd=%h rdy=%b err=%b, required 1 %b %h %h 0 0",
                           cur, t, bus.mem_valid, bus.mem_wr_rd, bus.mem_addr,
                           bus.mem_wdata, bus.req_ready, bus.req_err,
                           op_wr[cur], op_addr[cur], op_wd[cur]);
               end
               if (t == t_valid) begin
                  rd_before = bus.req_rdata;
                  if (scramble) begin
                     bus.req_addr[cur*AW +: AW]  = ~op_addr[cur];
                     bus.req_wr_rd[cur]          = ~op_wr[cur];
                     bus.req_wdata[cur*DW +: DW] = ~op_wd[cur];
                  end
               end
            end
         end while (t < t_done);
         checks++;
         if (bus.req_ready !== (exp_err ? '0 : oh) ||
             bus.req_err !== (exp_err ? oh : '0) || bus.mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL done port%0d t=%0d: ready=%b err=%b valid=%b, required ready=%b err=%b valid=0",
                     cur, t, bus.req_ready, bus.req_err, bus.mem_valid,
                     exp_err ? '0 : oh, exp_err ? oh : '0);
         end
         if (!exp_err) begin
            exp_rd = op_wr[cur] ? rd_before : ref_mem[op_addr[cur]];
            checks++;
            if (bus.req_rdata !== exp_rd) begin
               failures++;
               $display("FAIL rdata port%0d: got %h, required %h",
                        cur, bus.req_rdata, exp_rd);
            end
            if (op_wr[cur]) ref_mem[op_addr[cur]] = op_wd[cur];
         end
         bus.req_valid[cur] = 1'b0;
         pend[cur] = 1'b0;
         last_m = cur;
         t_valid = t_done + 2;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req_valid = '1;
      bus.req_wr_rd = '1;
      bus.req_addr  = '1;
      bus.req_wdata = '1;
      ref_init();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.mem_valid !== 1'b0 || bus.req_ready !== '0 ||
             bus.req_err !== '0 || bus.req_rdata !== '0 ||
             bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
             bus.mem_wr_rd !== 1'b0) begin
            failures++;
            $display("FAIL reset: valid=%b ready=%b err=%b rdata=%h addr=%h wd=%h wr=%b, required all 0",
                     bus.mem_valid, bus.req_ready, bus.req_err, bus.req_rdata,
                     bus.mem_addr, bus.mem_wdata, bus.mem_wr_rd);
         end
      end
      bus.req_valid = '0;
      rst = 1'b1;
   endtask

   task automatic test_contention();
      for (int i = 0; i < N; i++) begin
         op_wr[i]   = 1'b0;
         op_addr[i] = 8'h20 + 8'(i);
         op_wd[i]   = '0;
      end
      run_batch(4'b1111);
      run_batch(4'b1010);
   endtask

   task automatic test_write_read();
      op_wr[2]   = 1'b1;
      op_addr[2] = 8'h10;
      op_wd[2]   = 32'hDEADBEEF;
      run_batch(4'b0100);
      op_wr[2] = 1'b0;
      run_batch(4'b0100);
      @(negedge clk);
      checks++;
      if (bus.req_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL wr_rd_data: got %h, required DEADBEEF", bus.req_rdata);
      end
   endtask

   task automatic test_timeout();
      stall_en   = 1'b1;
      op_wr[1]   = 1'b0;
      op_addr[1] = stall_addr;
      op_wr[2]   = 1'b0;
      op_addr[2] = 8'h30;
      run_batch(4'b0110);
      stall_en = 1'b0;
   endtask

   task automatic test_expiry_edge();
      mem_lat    = TO - 1;
      op_wr[0]   = 1'b0;
      op_addr[0] = 8'h21;
      run_batch(4'b0001);
      mem_lat    = TO;
      op_wr[3]   = 1'b0;
      op_addr[3] = 8'h22;
      run_batch(4'b1000);
      mem_lat = 1;
   endtask

   task automatic test_reset_midop();
      int waited;
      stall_en = 1'b1;
      @(negedge clk);
      bus.req_valid[3] = 1'b1;
      bus.req_wr_rd[3] = 1'b0;
      bus.req_addr[3*AW +: AW] = stall_addr;
      waited = 0;
      while (bus.mem_valid !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (bus.mem_valid !== 1'b1) begin
         failures++;
         $display("FAIL midop_start: mem_valid=%b after %0d cycles, required 1",
                  bus.mem_valid, waited);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.mem_valid !== 1'b0 || bus.req_ready !== '0 || bus.req_err !== '0) begin
         failures++;
         $display("FAIL midop_reset: valid=%b ready=%b err=%b, required 0",
                  bus.mem_valid, bus.req_ready, bus.req_err);
      end
      bus.req_valid = '0;
      stall_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      ref_init();
      for (int i = 0; i < N; i++) begin
         op_wr[i]   = 1'b0;
         op_addr[i] = 8'h50 + 8'(i);
      end
      run_batch(4'b1111);
   endtask

   task automatic test_random();
      logic [N-1:0] mask;
      for (int b = 0; b < 30; b++) begin
         mask     = N'($urandom_range(1, (1 << N) - 1));
         mem_lat  = $urandom_range(1, 3);
         scramble = 1'($urandom % 2);
         for (int i = 0; i < N; i++) begin
            op_wr[i]   = 1'($urandom % 2);
            op_addr[i] = 8'h40 + 8'($urandom_range(0, 7));
            op_wd[i]   = $urandom;
         end
         run_batch(mask);
      end
      scramble = 1'b0;
      mem_lat  = 1;
   endtask

   initial begin
      test_reset();
      test_contention();
      test_write_read();
      test_timeout();
      test_expiry_edge();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
